condition_unit: RTL and testbench

CONDITION_UNIT -- requirements
Module: CONDITION_UNIT

---
 rtl/condition_unit.sv | 146 ++++++++++++++
 tb/tb_condition_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/condition_unit.sv
// Flag register, branch-condition evaluator and optional flag-save stack.
// Define CONDITION_UNIT_FLAG_STACK_EN to build the push/pop stack and its sticky error flags.
module condition_unit #(
    parameter int DATA_WIDTH  = 16,
    parameter int STACK_DEPTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [DATA_WIDTH-1:0] i_operand_a,
    input  logic [DATA_WIDTH-1:0] i_operand_b,
    input  logic                  i_flag_write,
    input  logic                  i_external_flag,
    input  logic                  i_eval_req,
    input  logic [4:0]            i_condition,
    input  logic                  i_flag_push,
    input  logic                  i_flag_pop,
    input  logic                  i_err_clear,
    output logic [7:0]            o_flags,
    output logic                  o_eval_valid,
    output logic                  o_branch_taken,
    output logic [4:0]            o_stack_count,
    output logic                  o_stack_overflow,
    output logic                  o_stack_underflow
);

    typedef enum logic {
        IDLE   = 1'b0,
        RESULT = 1'b1
    } state_t;

    state_t     r_state;
    logic [7:0] w_cmp_flags;
    logic       w_sel;
    logic       w_taken;

    assign w_cmp_flags = {
        i_external_flag,
        i_operand_a[DATA_WIDTH-1],
        ($signed(i_operand_a) < $signed(i_operand_b)),
        ($signed(i_operand_a) > $signed(i_operand_b)),
        (i_operand_a < i_operand_b),
        (i_operand_a > i_operand_b),
        (i_operand_a == i_operand_b),
        (i_operand_a == '0)
    };

    // Evaluation reads the registered flags, so a same-cycle write or pop is not seen.
    assign w_sel   = o_flags[i_condition[2:0]];
    assign w_taken = ~i_condition[4] | (i_condition[3] ^ w_sel);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state        <= IDLE;
            o_eval_valid   <= 1'b0;
            o_branch_taken <= 1'b0;
        end else begin
            case (r_state)
                IDLE, RESULT: begin
                    if (i_eval_req) begin
                        r_state        <= RESULT;
                        o_eval_valid   <= 1'b1;
                        o_branch_taken <= w_taken;
                    end else begin
                        r_state      <= IDLE;
                        o_eval_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    o_eval_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef CONDITION_UNIT_FLAG_STACK_EN
    localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [7:0]    r_stack [STACK_DEPTH];
    logic [4:0]    r_count;
    logic          r_overflow;
    logic          r_underflow;
    logic          w_push_only;
    logic          w_pop_only;
    logic          w_full;
    logic          w_empty;
    logic          w_do_push;
    logic          w_do_pop;
    logic [AW-1:0] w_push_idx;
    logic [AW-1:0] w_pop_idx;

    assign w_push_only = i_flag_push & ~i_flag_pop;
    assign w_pop_only  = i_flag_pop & ~i_flag_push;
    assign w_full      = (r_count == 5'(STACK_DEPTH));
    assign w_empty     = (r_count == 5'd0);
    assign w_do_push   = w_push_only & ~w_full;
    assign w_do_pop    = w_pop_only & ~w_empty;
    assign w_push_idx  = AW'(r_count);
    assign w_pop_idx   = AW'(r_count - 5'd1);

    // Entries are deliberately not reset; the count alone decides what is valid.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_stack[w_push_idx] <= o_flags;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_flags     <= 8'h00;
            r_count     <= 5'd0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_do_pop)          o_flags <= r_stack[w_pop_idx];
            else if (i_flag_write) o_flags <= w_cmp_flags;

            if (w_do_push)     r_count <= r_count + 5'd1;
            else if (w_do_pop) r_count <= r_count - 5'd1;

            // A same-cycle error event outranks the clear.
            if (w_push_only && w_full) r_overflow <= 1'b1;
            else if (i_err_clear)      r_overflow <= 1'b0;

            if (w_pop_only && w_empty) r_underflow <= 1'b1;
            else if (i_err_clear)      r_underflow <= 1'b0;
        end
    end

    assign o_stack_count     = r_count;
    assign o_stack_overflow  = r_overflow;
    assign o_stack_underflow = r_underflow;
`else
    logic [7:0] w_unused_stack;

    assign w_unused_stack = {i_flag_push, i_flag_pop, i_err_clear, 5'(STACK_DEPTH)};

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)           o_flags <= 8'h00;
        else if (i_flag_write) o_flags <= w_cmp_flags;
    end

    assign o_stack_count     = 5'd0;
    assign o_stack_overflow  = 1'b0;
    assign o_stack_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_condition_unit.sv
// Directed vector bench for condition_unit: flag generation, evaluation, stack and reset.
module tb_condition_unit;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [15:0] i_operand_a, i_operand_b;
    logic        i_flag_write, i_external_flag, i_eval_req;
    logic [4:0]  i_condition;
    logic        i_flag_push, i_flag_pop, i_err_clear;
    logic [7:0]  o_flags;
    logic        o_eval_valid, o_branch_taken;
    logic [4:0]  o_stack_count;
    logic        o_stack_overflow, o_stack_underflow;

    int n_checks = 0;
    int n_fail   = 0;

    condition_unit #(.DATA_WIDTH(16), .STACK_DEPTH(4)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_operand_a(i_operand_a), .i_operand_b(i_operand_b),
        .i_flag_write(i_flag_write), .i_external_flag(i_external_flag),
        .i_eval_req(i_eval_req), .i_condition(i_condition),
        .i_flag_push(i_flag_push), .i_flag_pop(i_flag_pop), .i_err_clear(i_err_clear),
        .o_flags(o_flags), .o_eval_valid(o_eval_valid), .o_branch_taken(o_branch_taken),
        .o_stack_count(o_stack_count), .o_stack_overflow(o_stack_overflow),
        .o_stack_underflow(o_stack_underflow)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        fw;
        logic        ext;
        logic        eval;
        logic [4:0]  cond;
        logic [7:0]  exp_flags;
        logic        exp_valid;
        logic        exp_taken;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(input logic [15:0] a, input logic [15:0] b, input logic fw,
                                input logic ext, input logic ev, input logic [4:0] cond,
                                input logic [7:0] ef, input logic ev_valid, input logic et);
        vec_t v;
        v.a = a; v.b = b; v.fw = fw; v.ext = ext; v.eval = ev; v.cond = cond;
        v.exp_flags = ef; v.exp_valid = ev_valid; v.exp_taken = et;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_operand_a = '0; i_operand_b = '0;
        i_flag_write = 1'b0; i_external_flag = 1'b0;
        i_eval_req = 1'b0; i_condition = '0;
        i_flag_push = 1'b0; i_flag_pop = 1'b0; i_err_clear = 1'b0;
    endtask

    task automatic write_flags(input logic [15:0] a, input logic [15:0] b);
        i_operand_a = a; i_operand_b = b; i_flag_write = 1'b1;
    endtask

    task automatic check_stack(input string name, input logic [4:0] cnt,
                               input logic ov, input logic un);
        check({name, "_count"}, 32'(o_stack_count), 32'(cnt));
        check({name, "_ovf"}, 32'(o_stack_overflow), 32'(ov));
        check({name, "_unf"}, 32'(o_stack_underflow), 32'(un));
    endtask

    logic [15:0] pa[5];
    logic [15:0] pb[5];
    logic [7:0]  pf[5];

    initial begin
        //             a         b         fw    ext   eval  cond       flags  valid taken
        vecs[0]  = mk(16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0, 5'b00000, 8'h64, 1'b0, 1'b0);
        vecs[1]  = mk(16'h0005, 16'h0005, 1'b1, 1'b1, 1'b1, 5'b10000, 8'h82, 1'b1, 1'b0);
        vecs[2]  = mk(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 5'b10001, 8'h82, 1'b1, 1'b1);
        vecs[3]  = mk(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 5'b11001, 8'h82, 1'b1, 1'b0);
        vecs[4]  = mk(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 5'b00101, 8'h82, 1'b1, 1'b1);
        vecs[5]  = mk(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 5'b11000, 8'h82, 1'b0, 1'b1);
        vecs[6]  = mk(16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 5'b00000, 8'h03, 1'b0, 1'b1);
        vecs[7]  = mk(16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1, 5'b10000, 8'h14, 1'b1, 1'b1);
        vecs[8]  = mk(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 5'b10000, 8'h14, 1'b1, 1'b0);
        vecs[9]  = mk(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 5'b11111, 8'h14, 1'b1, 1'b1);
        vecs[10] = mk(16'hFFFF, 16'h0001, 1'b1, 1'b1, 1'b0, 5'b00000, 8'hE4, 1'b0, 1'b1);
        vecs[11] = mk(16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b1, 5'b10111, 8'h18, 1'b1, 1'b1);
        vecs[12] = mk(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 5'b10011, 8'h18, 1'b1, 1'b1);
        vecs[13] = mk(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 5'b11011, 8'h18, 1'b1, 1'b0);

        pa[0] = 16'h0000; pb[0] = 16'h0000; pf[0] = 8'h03;
        pa[1] = 16'h0001; pb[1] = 16'h0000; pf[1] = 8'h14;
        pa[2] = 16'h0000; pb[2] = 16'h0001; pf[2] = 8'h29;
        pa[3] = 16'h8000; pb[3] = 16'h0001; pf[3] = 8'h64;
        pa[4] = 16'h0005; pb[4] = 16'h0005; pf[4] = 8'h02;

        idle_inputs();
        i_reset = 1'b1;
        #1;
        check("rst_flags", 32'(o_flags), 32'h0);
        check("rst_valid", 32'(o_eval_valid), 32'h0);
        check("rst_taken", 32'(o_branch_taken), 32'h0);
        check_stack("rst", 5'd0, 1'b0, 1'b0);
        tick();
        i_reset = 1'b0;
        tick();

        for (int i = 0; i < 14; i++) begin
            idle_inputs();
            i_operand_a = vecs[i].a; i_operand_b = vecs[i].b;
            i_flag_write = vecs[i].fw; i_external_flag = vecs[i].ext;
            i_eval_req = vecs[i].eval; i_condition = vecs[i].cond;
            tick();
            check($sformatf("vec%0d_flags", i), 32'(o_flags), 32'(vecs[i].exp_flags));
            check($sformatf("vec%0d_valid", i), 32'(o_eval_valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_taken", i), 32'(o_branch_taken), 32'(vecs[i].exp_taken));
        end
        idle_inputs();

`ifdef CONDITION_UNIT_FLAG_STACK_EN
        for (int i = 0; i < 5; i++) begin
            idle_inputs();
            write_flags(pa[i], pb[i]);
            tick();
            check($sformatf("push%0d_flags", i), 32'(o_flags), 32'(pf[i]));
            idle_inputs();
            i_flag_push = 1'b1;
            tick();
            check_stack($sformatf("push%0d", i), (i < 4) ? 5'(i + 1) : 5'd4, (i == 4), 1'b0);
        end
        for (int k = 0; k < 4; k++) begin
            idle_inputs();
            i_flag_pop = 1'b1;
            tick();
            check($sformatf("pop%0d_flags", k), 32'(o_flags), 32'(pf[3 - k]));
            check($sformatf("pop%0d_count", k), 32'(o_stack_count), 32'(3 - k));
        end
        idle_inputs();
        i_flag_pop = 1'b1; i_err_clear = 1'b1;
        tick();
        check("pop_empty_flags", 32'(o_flags), 32'h03);
        check_stack("pop_empty", 5'd0, 1'b0, 1'b1);
        idle_inputs();
        i_err_clear = 1'b1;
        tick();
        check_stack("err_clear", 5'd0, 1'b0, 1'b0);

        idle_inputs();
        write_flags(16'h0001, 16'h0000);
        i_flag_push = 1'b1;
        tick();
        check("push_write_flags", 32'(o_flags), 32'h14);
        check_stack("push_write", 5'd1, 1'b0, 1'b0);
        idle_inputs();
        write_flags(16'h8000, 16'h0001);
        i_flag_pop = 1'b1;
        tick();
        check("pop_write_flags", 32'(o_flags), 32'h03);
        check_stack("pop_write", 5'd0, 1'b0, 1'b0);
        idle_inputs();
        write_flags(16'h0000, 16'h0001);
        i_flag_push = 1'b1; i_flag_pop = 1'b1;
        tick();
        check("pushpop_flags", 32'(o_flags), 32'h29);
        check_stack("pushpop", 5'd0, 1'b0, 1'b0);
        idle_inputs();
        i_flag_push = 1'b1;
        tick();
        tick();
        check_stack("pre_rst", 5'd2, 1'b0, 1'b0);
`else
        idle_inputs();
        write_flags(16'h0001, 16'h0000);
        tick();
        check("nostk_flags", 32'(o_flags), 32'h14);
        for (int k = 0; k < 4; k++) begin
            idle_inputs();
            i_flag_push = (k != 1);
            i_flag_pop  = (k != 0);
            i_err_clear = (k == 3);
            tick();
            check($sformatf("nostk%0d_flags", k), 32'(o_flags), 32'h14);
            check_stack($sformatf("nostk%0d", k), 5'd0, 1'b0, 1'b0);
        end
`endif

        idle_inputs();
        i_eval_req = 1'b1; i_condition = 5'b00000;
        tick();
        check("pre_rst_valid", 32'(o_eval_valid), 32'h1);
        check("pre_rst_taken", 32'(o_branch_taken), 32'h1);
        #2;
        i_reset = 1'b1;
        #1;
        check("midrst_flags", 32'(o_flags), 32'h0);
        check("midrst_valid", 32'(o_eval_valid), 32'h0);
        check("midrst_taken", 32'(o_branch_taken), 32'h0);
        check_stack("midrst", 5'd0, 1'b0, 1'b0);
        tick();
        i_eval_req = 1'b0;
        i_reset = 1'b0;
        tick();
        check("post_rst_valid", 32'(o_eval_valid), 32'h0);
        check("post_rst_flags", 32'(o_flags), 32'h0);
        tick();
        check("post_rst_valid2", 32'(o_eval_valid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
